// File: rtl/stream_sched_pkg.sv
// stream_sched_pkg: shared types for the packet-level QoS stream scheduler
package stream_sched_pkg;
    typedef enum logic {ARB, XFER} state_e;
endpackage

// File: rtl/stream_qos_pick.sv
// stream_qos_pick: combinational winner select; urgency first, then highest QoS,
// then first candidate at or after the round-robin pointer
module stream_qos_pick #(
    parameter int STREAM_COUNT = 4,
    parameter int T_QOS__WIDTH = 4,
    parameter int T_ID___WIDTH = $clog2(STREAM_COUNT)
) (
    input  logic [STREAM_COUNT-1:0]              valid_i,
    input  logic [STREAM_COUNT*T_QOS__WIDTH-1:0] qos_i,
    input  logic [STREAM_COUNT-1:0]              urgent_i,
    input  logic [T_ID___WIDTH-1:0]              rr_ptr_i,
    output logic [T_ID___WIDTH-1:0]              winner_o,
    output logic                                 any_valid_o
);
    localparam logic [T_ID___WIDTH:0] COUNT = (T_ID___WIDTH+1)'(STREAM_COUNT);

    logic [T_QOS__WIDTH-1:0] qos_a [STREAM_COUNT];
    logic [STREAM_COUNT-1:0] cand;
    logic [T_QOS__WIDTH-1:0] max_qos;
    logic [T_ID___WIDTH:0]   sum;
    logic [T_ID___WIDTH-1:0] idx;
    logic                    found;

    always_comb begin
        cand    = |(valid_i & urgent_i) ? (valid_i & urgent_i) : valid_i;
        max_qos = '0;
        for (int i = 0; i < STREAM_COUNT; i++) begin
            qos_a[i] = qos_i[i*T_QOS__WIDTH +: T_QOS__WIDTH];
            if (cand[i] && qos_a[i] > max_qos) max_qos = qos_a[i];
        end
        winner_o = '0;
        found    = 1'b0;
        sum      = '0;
        idx      = '0;
        // Walk from rr_ptr with wrap; the first max-QoS candidate wins
        for (int i = 0; i < STREAM_COUNT; i++) begin
            sum = {1'b0, rr_ptr_i} + (T_ID___WIDTH+1)'(i);
            idx = (sum >= COUNT) ? T_ID___WIDTH'(sum - COUNT) : sum[T_ID___WIDTH-1:0];
            if (!found && cand[idx] && qos_a[idx] == max_qos) begin
                winner_o = idx;
                found    = 1'b1;
            end
        end
        any_valid_o = |valid_i;
    end
endmodule

// File: rtl/stream_qos_scheduler.sv
// stream_qos_scheduler: packet-level N:1 scheduler with QoS priority, round-robin
// tie-break and starvation aging, forwarding beats through a one-deep output register
module stream_qos_scheduler
    import stream_sched_pkg::*;
#(
    parameter int T_DATA_WIDTH = 8,
    parameter int T_QOS__WIDTH = 4,
    parameter int STREAM_COUNT = 4,
    parameter int T_ID___WIDTH = $clog2(STREAM_COUNT),
    parameter int AGE_WIDTH    = 3
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic [STREAM_COUNT*T_DATA_WIDTH-1:0] s_data_i,
    input  logic [STREAM_COUNT*T_QOS__WIDTH-1:0] s_qos_i,
    input  logic [STREAM_COUNT-1:0]              s_last_i,
    input  logic [STREAM_COUNT-1:0]              s_valid_i,
    output logic [STREAM_COUNT-1:0]              s_ready_o,
    output logic [T_DATA_WIDTH-1:0]              m_data_o,
    output logic [T_QOS__WIDTH-1:0]              m_qos_o,
    output logic [T_ID___WIDTH-1:0]              m_id_o,
    output logic                                 m_last_o,
    output logic                                 m_valid_o,
    input  logic                                 m_ready_i
);
    localparam logic [AGE_WIDTH-1:0]    AGE_MAX = '1;
    localparam logic [T_ID___WIDTH-1:0] LAST_ID = T_ID___WIDTH'(STREAM_COUNT - 1);

    state_e                  state_q, state_d;
    logic [T_ID___WIDTH-1:0] grant_q, grant_d, rr_ptr_q, rr_ptr_d, winner;
    logic [T_QOS__WIDTH-1:0] pkt_qos_q, pkt_qos_d;
    logic [AGE_WIDTH-1:0]    age_q [STREAM_COUNT];
    logic [AGE_WIDTH-1:0]    age_d [STREAM_COUNT];
    logic [T_DATA_WIDTH-1:0] m_data_q, m_data_d;
    logic [T_QOS__WIDTH-1:0] m_qos_q, m_qos_d;
    logic [T_ID___WIDTH-1:0] m_id_q, m_id_d;
    logic                    m_last_q, m_last_d, m_valid_q, m_valid_d;
    logic [T_DATA_WIDTH-1:0] data_a [STREAM_COUNT];
    logic [T_QOS__WIDTH-1:0] qos_a  [STREAM_COUNT];
    logic [STREAM_COUNT-1:0] urgent;
    logic                    any_valid, slot_free, accept;

    always_comb begin
        for (int i = 0; i < STREAM_COUNT; i++) begin
            data_a[i] = s_data_i[i*T_DATA_WIDTH +: T_DATA_WIDTH];
            qos_a[i]  = s_qos_i[i*T_QOS__WIDTH +: T_QOS__WIDTH];
            urgent[i] = age_q[i] == AGE_MAX;
        end
    end

    stream_qos_pick #(
        .STREAM_COUNT(STREAM_COUNT),
        .T_QOS__WIDTH(T_QOS__WIDTH),
        .T_ID___WIDTH(T_ID___WIDTH)
    ) u_pick (
        .valid_i    (s_valid_i),
        .qos_i      (s_qos_i),
        .urgent_i   (urgent),
        .rr_ptr_i   (rr_ptr_q),
        .winner_o   (winner),
        .any_valid_o(any_valid)
    );

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        rr_ptr_d  = rr_ptr_q;
        pkt_qos_d = pkt_qos_q;
        age_d     = age_q;
        m_data_d  = m_data_q;
        m_qos_d   = m_qos_q;
        m_id_d    = m_id_q;
        m_last_d  = m_last_q;
        m_valid_d = m_valid_q;
        slot_free = !m_valid_q || m_ready_i;
        s_ready_o = '0;
        if (state_q == XFER) s_ready_o[grant_q] = slot_free;
        accept = s_valid_i[grant_q] && s_ready_o[grant_q];
        if (state_q == ARB && any_valid) begin
            state_d   = XFER;
            grant_d   = winner;
            pkt_qos_d = qos_a[winner];
            // Losers that were waiting get older; idle streams keep their age
            for (int i = 0; i < STREAM_COUNT; i++)
                if (s_valid_i[i])
                    age_d[i] = (T_ID___WIDTH'(i) == winner) ? '0 :
                               (age_q[i] == AGE_MAX) ? AGE_MAX : age_q[i] + 1'b1;
        end
        if (accept) begin
            m_data_d  = data_a[grant_q];
            m_last_d  = s_last_i[grant_q];
            m_id_d    = grant_q;
            m_qos_d   = pkt_qos_q;
            m_valid_d = 1'b1;
            if (s_last_i[grant_q]) begin
                state_d  = ARB;
                rr_ptr_d = (grant_q == LAST_ID) ? '0 : grant_q + 1'b1;
            end
        end else if (m_valid_q && m_ready_i) begin
            m_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ARB;
            grant_q   <= '0;
            rr_ptr_q  <= '0;
            pkt_qos_q <= '0;
            age_q     <= '{default: '0};
            m_data_q  <= '0;
            m_qos_q   <= '0;
            m_id_q    <= '0;
            m_last_q  <= 1'b0;
            m_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            rr_ptr_q  <= rr_ptr_d;
            pkt_qos_q <= pkt_qos_d;
            age_q     <= age_d;
            m_data_q  <= m_data_d;
            m_qos_q   <= m_qos_d;
            m_id_q    <= m_id_d;
            m_last_q  <= m_last_d;
            m_valid_q <= m_valid_d;
        end
    end

    assign m_data_o  = m_data_q;
    assign m_qos_o   = m_qos_q;
    assign m_id_o    = m_id_q;
    assign m_last_o  = m_last_q;
    assign m_valid_o = m_valid_q;
endmodule

// File: tb/tb_stream_qos_scheduler.sv
// tb_stream_qos_scheduler: vector table, directed corner sequences and randomized
// packets checked against a transaction-level scheduling model
module tb_stream_qos_scheduler;
    localparam int N = 4, DW = 8, QW = 4, IW = 2, AMAX = 7;

    logic            clk_i = 1'b0, rst_i = 1'b1;
    logic [N*DW-1:0] s_data_i;
    logic [N*QW-1:0] s_qos_i;
    logic [N-1:0]    s_last_i, s_valid_i, s_ready_o;
    logic [DW-1:0]   m_data_o;
    logic [QW-1:0]   m_qos_o;
    logic [IW-1:0]   m_id_o;
    logic            m_last_o, m_valid_o, m_ready_i;

    always #5 clk_i = ~clk_i;

    stream_qos_scheduler dut (
        .clk_i(clk_i), .rst_i(rst_i), .s_data_i(s_data_i), .s_qos_i(s_qos_i),
        .s_last_i(s_last_i), .s_valid_i(s_valid_i), .s_ready_o(s_ready_o),
        .m_data_o(m_data_o), .m_qos_o(m_qos_o), .m_id_o(m_id_o),
        .m_last_o(m_last_o), .m_valid_o(m_valid_o), .m_ready_i(m_ready_i)
    );

    typedef struct packed {
        logic [DW-1:0] d;
        logic [IW-1:0] id;
        logic [QW-1:0] q;
        logic          l;
    } beat_t;

    typedef struct packed {
        logic [N-1:0]  valid, last;
        logic [DW-1:0] dbase;
        logic [N-1:0]  e_sready;
        logic          e_mvalid;
        logic [DW-1:0] e_mdata;
        logic [IW-1:0] e_mid;
        logic [QW-1:0] e_mqos;
        logic          e_mlast;
    } vec_t;

    int n_chk = 0, n_fail = 0, cyc = 0;
    logic [DW-1:0] b_data [N][64];
    logic          b_last [N][64];
    logic [QW-1:0] b_qos  [N][64];
    int            b_cnt [N], b_rd [N];
    beat_t         cap_q[$], exp_q[$];
    int            cap_t[$];
    logic          mr = 1'b1, rnd_mr = 1'b0;
    logic [N-1:0]  smp_sready;
    logic          smp_mvalid;
    logic [DW-1:0] smp_mdata;
    vec_t          vt [12];
    int            rr_exp [5] = '{0, 1, 2, 3, 0};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [N-1:0] v, input logic [N-1:0] l, input logic [DW-1:0] db,
                                input logic [N-1:0] sr, input logic mv, input logic [DW-1:0] md,
                                input logic [IW-1:0] id, input logic [QW-1:0] q, input logic ml);
        return '{v, l, db, sr, mv, md, id, q, ml};
    endfunction

    task automatic add_pkt(input int s, input int len, input logic [QW-1:0] q, input logic [DW-1:0] base);
        for (int k = 0; k < len; k++) begin
            b_data[s][b_cnt[s]] = base + DW'(k);
            b_last[s][b_cnt[s]] = (k == len - 1);
            b_qos[s][b_cnt[s]]  = q;
            b_cnt[s]++;
        end
    endtask

    // One clock: drive source heads, sample at the falling edge, pop accepted beats
    task automatic step();
        logic [N-1:0] acc;
        for (int s = 0; s < N; s++) begin
            s_valid_i[s]         = b_rd[s] < b_cnt[s];
            s_data_i[s*DW +: DW] = s_valid_i[s] ? b_data[s][b_rd[s]] : '0;
            s_qos_i[s*QW +: QW]  = s_valid_i[s] ? b_qos[s][b_rd[s]] : '0;
            s_last_i[s]          = s_valid_i[s] && b_last[s][b_rd[s]];
        end
        m_ready_i = rnd_mr ? ($urandom_range(3) != 0) : mr;
        @(negedge clk_i);
        cyc++;
        smp_sready = s_ready_o;
        smp_mvalid = m_valid_o;
        smp_mdata  = m_data_o;
        check("s_ready_onehot", 32'($countones(s_ready_o) <= 1), 32'd1);
        acc = s_valid_i & s_ready_o;
        if (m_valid_o && m_ready_i) begin
            cap_q.push_back({m_data_o, m_id_o, m_qos_o, m_last_o});
            cap_t.push_back(cyc);
        end
        @(posedge clk_i);
        #1;
        for (int s = 0; s < N; s++) if (acc[s]) b_rd[s]++;
    endtask

    task automatic do_reset(input int n);
        rst_i = 1'b1;
        for (int s = 0; s < N; s++) begin
            b_cnt[s] = 0;
            b_rd[s]  = 0;
        end
        repeat (n) step();
        rst_i = 1'b0;
        cap_q.delete();
        cap_t.delete();
    endtask

    task automatic run_until(input int n, input int budget, input string name);
        int t = 0;
        while (cap_q.size() < n && t < budget) begin
            step();
            t++;
        end
        check(name, 32'(cap_q.size() >= n ? n : cap_q.size()), 32'(n));
    endtask

    // Transaction-level reference: one decision per packet over streams with pending beats
    task automatic model();
        int rd [N];
        int age [N];
        int rr = 0, w, mq;
        logic any, urg;
        logic [QW-1:0] q0;
        exp_q.delete();
        for (int s = 0; s < N; s++) begin
            rd[s]  = 0;
            age[s] = 0;
        end
        for (int g = 0; g < 1000; g++) begin
            any = 1'b0;
            urg = 1'b0;
            for (int s = 0; s < N; s++) if (rd[s] < b_cnt[s]) begin
                any = 1'b1;
                if (age[s] == AMAX) urg = 1'b1;
            end
            if (!any) break;
            mq = -1;
            w  = -1;
            for (int s = 0; s < N; s++)
                if (rd[s] < b_cnt[s] && (!urg || age[s] == AMAX) && int'(b_qos[s][rd[s]]) > mq)
                    mq = int'(b_qos[s][rd[s]]);
            for (int k = 0; k < N; k++) begin
                int s = (rr + k) % N;
                if (w < 0 && rd[s] < b_cnt[s] && (!urg || age[s] == AMAX) && int'(b_qos[s][rd[s]]) == mq)
                    w = s;
            end
            for (int s = 0; s < N; s++)
                if (rd[s] < b_cnt[s]) age[s] = (s == w) ? 0 : (age[s] < AMAX ? age[s] + 1 : AMAX);
            q0 = b_qos[w][rd[w]];
            for (int k = 0; k < 64; k++) begin
                exp_q.push_back({b_data[w][rd[w]], IW'(w), q0, b_last[w][rd[w]]});
                rd[w]++;
                if (b_last[w][rd[w]-1]) break;
            end
            rr = (w + 1) % N;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        do_reset(2);
        // Priority table: qos {1,5,3,0}, 2-beat packets, stream s carries dbase+s
        for (int r = 0; r < 4; r++) vt[r] = mk(4'h0, 4'h0, 8'h00, 4'h0, 1'b0, 8'h00, 2'd0, 4'd0, 1'b0);
        vt[4]  = mk(4'hF, 4'h0, 8'h00, 4'h0, 1'b0, 8'h00, 2'd0, 4'd0, 1'b0);
        vt[5]  = mk(4'hF, 4'h0, 8'h20, 4'h2, 1'b0, 8'h00, 2'd0, 4'd0, 1'b0);
        vt[6]  = mk(4'hF, 4'hF, 8'h30, 4'h2, 1'b1, 8'h21, 2'd1, 4'd5, 1'b0);
        vt[7]  = mk(4'hD, 4'h0, 8'h40, 4'h0, 1'b1, 8'h31, 2'd1, 4'd5, 1'b1);
        vt[8]  = mk(4'hD, 4'h0, 8'h50, 4'h4, 1'b0, 8'h31, 2'd1, 4'd5, 1'b1);
        vt[9]  = mk(4'hD, 4'hF, 8'h60, 4'h4, 1'b1, 8'h52, 2'd2, 4'd3, 1'b0);
        vt[10] = mk(4'h0, 4'h0, 8'h00, 4'h0, 1'b1, 8'h62, 2'd2, 4'd3, 1'b1);
        vt[11] = mk(4'h0, 4'h0, 8'h00, 4'h0, 1'b0, 8'h62, 2'd2, 4'd3, 1'b1);
        s_qos_i = {4'd0, 4'd3, 4'd5, 4'd1};
        for (int r = 0; r < 12; r++) begin
            s_valid_i = vt[r].valid;
            s_last_i  = vt[r].last;
            for (int s = 0; s < N; s++) s_data_i[s*DW +: DW] = vt[r].dbase + DW'(s);
            m_ready_i = 1'b1;
            @(negedge clk_i);
            check($sformatf("vec%0d s_ready", r), 32'(s_ready_o), 32'(vt[r].e_sready));
            check($sformatf("vec%0d m_valid", r), 32'(m_valid_o), 32'(vt[r].e_mvalid));
            check($sformatf("vec%0d m_data", r), 32'(m_data_o), 32'(vt[r].e_mdata));
            check($sformatf("vec%0d m_id", r), 32'(m_id_o), 32'(vt[r].e_mid));
            check($sformatf("vec%0d m_qos", r), 32'(m_qos_o), 32'(vt[r].e_mqos));
            check($sformatf("vec%0d m_last", r), 32'(m_last_o), 32'(vt[r].e_mlast));
            @(posedge clk_i);
            #1;
        end

        // Round-robin among equal QoS, single-beat packets, one bubble apart
        do_reset(1);
        for (int s = 0; s < N; s++) begin
            add_pkt(s, 1, 4'd2, 8'hA0 + DW'(s));
            add_pkt(s, 1, 4'd2, 8'hA0 + DW'(s));
        end
        run_until(5, 40, "rr_count");
        for (int k = 0; k < 5; k++) begin
            check($sformatf("rr_id%0d", k), 32'(cap_q[k].id), 32'(rr_exp[k]));
            if (k > 0) check($sformatf("rr_gap%0d", k), 32'(cap_t[k] - cap_t[k-1]), 32'd2);
        end

        // Aging: low-QoS stream 0 must win every 8th decision against stream 1
        do_reset(1);
        for (int p = 0; p < 9; p++) add_pkt(0, 1, 4'd1, 8'h10 + DW'(p));
        for (int p = 0; p < 16; p++) add_pkt(1, 1, 4'd7, 8'h40 + DW'(p));
        run_until(16, 80, "age_count");
        for (int k = 0; k < 16; k++)
            check($sformatf("age_id%0d", k), 32'(cap_q[k].id), (k == 7 || k == 15) ? 32'd0 : 32'd1);

        // Backpressure mid-packet
        do_reset(1);
        add_pkt(2, 4, 4'd4, 8'hC0);
        mr = 1'b1;
        run_until(1, 10, "bp_first");
        mr = 1'b0;
        repeat (3) begin
            step();
            check("bp_sready", 32'(smp_sready[2]), 32'd0);
            check("bp_mdata_hold", 32'(smp_mdata), 32'hC1);
            check("bp_mvalid_hold", 32'(smp_mvalid), 32'd1);
        end
        mr = 1'b1;
        run_until(4, 20, "bp_count");
        repeat (3) step();
        check("bp_no_dup", 32'(cap_q.size()), 32'd4);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("bp_data%0d", k), 32'(cap_q[k].d), 32'hC0 + 32'(k));
            check($sformatf("bp_last%0d", k), 32'(cap_q[k].l), 32'(k == 3));
        end

        // Reset on beat 2 of 4 of stream 3 (rr_ptr had moved to 3)
        do_reset(1);
        add_pkt(2, 1, 4'd1, 8'h50);
        add_pkt(3, 4, 4'd1, 8'h60);
        run_until(2, 20, "mid_count");
        check("mid_first_id", 32'(cap_q[0].id), 32'd2);
        check("mid_second_id", 32'(cap_q[1].id), 32'd3);
        do_reset(1);
        add_pkt(1, 1, 4'd1, 8'h70);
        add_pkt(3, 1, 4'd1, 8'h80);
        step();
        check("mid_mvalid_after_rst", 32'(smp_mvalid), 32'd0);
        check("mid_sready_after_rst", 32'(smp_sready), 32'd0);
        run_until(1, 10, "mid_rearb");
        check("mid_rr_reset_id", 32'(cap_q[0].id), 32'd1);
        check("mid_rr_reset_data", 32'(cap_q[0].d), 32'h70);

        // Randomized packets and backpressure against the reference model
        for (int r = 0; r < 20; r++) begin
            do_reset(1);
            for (int s = 0; s < N; s++) begin
                int np = $urandom_range(6);
                for (int p = 0; p < np; p++)
                    add_pkt(s, $urandom_range(1, 3), QW'($urandom_range(15)), DW'($urandom));
            end
            model();
            rnd_mr = 1'b1;
            run_until(exp_q.size(), 600, $sformatf("rnd%0d_count", r));
            repeat (3) step();
            rnd_mr = 1'b0;
            check($sformatf("rnd%0d_size", r), 32'(cap_q.size()), 32'(exp_q.size()));
            for (int k = 0; k < exp_q.size() && k < cap_q.size(); k++)
                check($sformatf("rnd%0d_beat%0d", r, k), 32'(cap_q[k]), 32'(exp_q[k]));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
